// File: rtl/pc_fetch_ctrl_pkg.sv
// Shared types and constants for the fetch-stage PC controller.
package pc_fetch_ctrl_pkg;

  localparam int XLEN = 32;

  typedef logic [XLEN-1:0] word_t;

  typedef enum logic [1:0] {
    PCF_IDLE  = 2'd0,
    PCF_FETCH = 2'd1,
    PCF_HOLD  = 2'd2
  } pcf_state_e;

  localparam word_t PC_RESET = 32'h0000_3000;
  localparam word_t EX_INIT  = 32'h0000_4180;

  // Sequential PC advance; wraps modulo 2^32 with no alignment check.
  function automatic word_t pc_plus4(input word_t pc);
    return pc + word_t'(4);
  endfunction

endpackage

// File: rtl/pc_fetch_ctrl_if.sv
// Instruction-memory request/acknowledge bus between the fetch controller and IM.
interface pc_fetch_ctrl_if;
  import pc_fetch_ctrl_pkg::*;

  logic  imem_req;
  word_t imem_addr;
  logic  imem_ack;
  word_t imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ack,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ack,
    output imem_rdata
  );

endinterface

// File: rtl/pc_fetch_ctrl_fetch_skid.sv
// One-entry {pc, instr} buffer catching a returned word while decode is stalled.
module fetch_skid
  import pc_fetch_ctrl_pkg::*;
(
  input  logic  clk,
  input  logic  reset,
  input  logic  load_i,
  input  logic  unload_i,
  input  logic  clear_i,
  input  word_t pc_i,
  input  word_t instr_i,
  output logic  valid_o,
  output word_t pc_o,
  output word_t instr_o
);

  logic  valid_q;
  word_t pc_q;
  word_t instr_q;

  // Clear (redirect) beats a same-cycle load so a squashed word never lands.
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= 1'b0;
    end else if (clear_i) begin
      valid_q <= 1'b0;
    end else if (load_i) begin
      valid_q <= 1'b1;
    end else if (unload_i) begin
      valid_q <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (load_i && !clear_i) begin
      pc_q    <= pc_i;
      instr_q <= instr_i;
    end
  end

  assign valid_o = valid_q;
  assign pc_o    = pc_q;
  assign instr_o = instr_q;

endmodule

// File: rtl/pc_fetch_ctrl.sv
// Fetch-stage controller: owns the PC, sequences IM req/ack fetches, and feeds F/D.
module pc_fetch_ctrl
  import pc_fetch_ctrl_pkg::*;
#(
  parameter word_t RESET_PC = PC_RESET,
  parameter word_t EX_ENTRY = EX_INIT
) (
  input  logic  clk,
  input  logic  reset,
  input  logic  stall,
  input  logic  redir_valid,
  input  word_t redir_pc,
  input  logic  exc_req,
  input  logic  eret_req,
  input  word_t epc,
  pc_fetch_ctrl_if.master imem,
  output logic  if_valid,
  output word_t if_pc,
  output word_t if_instr
);

  pcf_state_e state_q, state_d;
  word_t      pc_q, pc_d;
  logic       pend_valid_q, pend_valid_d;
  word_t      pend_pc_q, pend_pc_d;
  logic       if_valid_q, if_valid_d;
  word_t      if_pc_q, if_pc_d;
  word_t      if_instr_q, if_instr_d;

  logic       redirect;
  word_t      redir_tgt;
  logic       in_fetch, in_hold;
  logic       fetch_ack, drop_word, take_word;
  logic       to_if, to_skid, from_skid;
  logic       skid_valid;
  word_t      skid_pc, skid_instr;

  // Redirect priority: exception entry, then eret, then taken branch/jump.
  always_comb begin
    redirect = exc_req | eret_req | redir_valid;
    if (exc_req) begin
      redir_tgt = EX_ENTRY;
    end else if (eret_req) begin
      redir_tgt = epc;
    end else begin
      redir_tgt = redir_pc;
    end
  end

  always_comb begin
    in_fetch  = (state_q == PCF_FETCH);
    in_hold   = (state_q == PCF_HOLD);
    fetch_ack = in_fetch & imem.imem_ack;
    drop_word = fetch_ack & (redirect | pend_valid_q);
    take_word = fetch_ack & ~drop_word;
    to_if     = take_word & (~if_valid_q | ~stall);
    to_skid   = take_word & if_valid_q & stall;
    from_skid = in_hold & skid_valid & ~redirect & ~stall;
  end

  fetch_skid u_skid (
    .clk      (clk),
    .reset    (reset),
    .load_i   (to_skid),
    .unload_i (from_skid),
    .clear_i  (redirect),
    .pc_i     (pc_q),
    .instr_i  (imem.imem_rdata),
    .valid_o  (skid_valid),
    .pc_o     (skid_pc),
    .instr_o  (skid_instr)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= PCF_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      PCF_IDLE:  state_d = PCF_FETCH;
      PCF_FETCH: if (to_skid) state_d = PCF_HOLD;
      PCF_HOLD:  if (redirect || !stall) state_d = PCF_FETCH;
      default:   state_d = PCF_IDLE;
    endcase
  end

  always_comb begin
    imem.imem_req  = (state_q == PCF_FETCH);
    imem.imem_addr = pc_q;
    if_valid       = if_valid_q;
    if_pc          = if_pc_q;
    if_instr       = if_instr_q;
  end

  // A redirect seen while a request is outstanding is parked in pend_pc so the
  // address stays stable until the ack; the returning word is then squashed.
  always_comb begin
    pc_d         = pc_q;
    pend_valid_d = pend_valid_q;
    pend_pc_d    = pend_pc_q;
    if_valid_d   = if_valid_q;
    if_pc_d      = if_pc_q;
    if_instr_d   = if_instr_q;

    if (drop_word) begin
      pc_d         = redirect ? redir_tgt : pend_pc_q;
      pend_valid_d = 1'b0;
    end else if (take_word) begin
      pc_d = pc_plus4(pc_q);
    end else if (redirect && !in_fetch) begin
      pc_d = redir_tgt;
    end

    if (in_fetch && !imem.imem_ack && redirect) begin
      pend_valid_d = 1'b1;
      pend_pc_d    = redir_tgt;
    end

    if (if_valid_q && !stall) begin
      if_valid_d = 1'b0;
    end
    if (to_if) begin
      if_valid_d = 1'b1;
      if_pc_d    = pc_q;
      if_instr_d = imem.imem_rdata;
    end else if (from_skid) begin
      if_valid_d = 1'b1;
      if_pc_d    = skid_pc;
      if_instr_d = skid_instr;
    end
    if (redirect) begin
      if_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q         <= RESET_PC;
      pend_valid_q <= 1'b0;
      if_valid_q   <= 1'b0;
      if_pc_q      <= '0;
      if_instr_q   <= '0;
    end else begin
      pc_q         <= pc_d;
      pend_valid_q <= pend_valid_d;
      if_valid_q   <= if_valid_d;
      if_pc_q      <= if_pc_d;
      if_instr_q   <= if_instr_d;
    end
  end

  always_ff @(posedge clk) begin
    pend_pc_q <= pend_pc_d;
  end

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Bench for pc_fetch_ctrl: cycle table of bus/F-D expectations plus a decode-side scoreboard.
module tb_pc_fetch_ctrl;
  import pc_fetch_ctrl_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic  reset, stall, redir_valid, exc_req, eret_req, mem_rdy;
  word_t redir_pc, epc;
  logic  if_valid;
  word_t if_pc, if_instr;

  int checks = 0;
  int errors = 0;

  pc_fetch_ctrl_if bus();

  function automatic word_t mem_word(input word_t a);
    return a ^ 32'h5A5A_A5A5;
  endfunction

  assign bus.imem_ack   = bus.imem_req & mem_rdy;
  assign bus.imem_rdata = mem_word(bus.imem_addr);

  pc_fetch_ctrl dut (
    .clk         (clk),
    .reset       (reset),
    .stall       (stall),
    .redir_valid (redir_valid),
    .redir_pc    (redir_pc),
    .exc_req     (exc_req),
    .eret_req    (eret_req),
    .epc         (epc),
    .imem        (bus),
    .if_valid    (if_valid),
    .if_pc       (if_pc),
    .if_instr    (if_instr)
  );

  typedef struct {
    logic  rst, stl, rdy, rv;
    word_t rpc;
    logic  exc, eret;
    word_t epc;
    logic  chk, req;
    word_t addr;
    logic  v, ck_pc;
    word_t ifpc;
  } vec_t;

  typedef struct {
    word_t pc;
    word_t instr;
  } exp_t;

  vec_t tbl[$];
  exp_t sbq[$];

  function automatic vec_t mk(input logic rst, input logic stl, input logic rdy, input logic rv,
                              input word_t rpc, input logic exc, input logic eret, input word_t ep,
                              input logic chk, input logic req, input word_t addr, input logic v,
                              input logic ck_pc, input word_t ifpc);
    vec_t r;
    r.rst = rst; r.stl = stl; r.rdy = rdy; r.rv = rv; r.rpc = rpc;
    r.exc = exc; r.eret = eret; r.epc = ep;
    r.chk = chk; r.req = req; r.addr = addr; r.v = v; r.ck_pc = ck_pc; r.ifpc = ifpc;
    return r;
  endfunction

  task automatic check(input string name, input word_t act, input word_t exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic push_exp(input word_t pc);
    exp_t e;
    e.pc    = pc;
    e.instr = mem_word(pc);
    sbq.push_back(e);
  endtask

  task automatic drive(input logic rst, input logic stl, input logic rdy, input logic rv,
                       input word_t rpc, input logic exc, input logic eret, input word_t ep);
    reset = rst; stall = stl; mem_rdy = rdy; redir_valid = rv; redir_pc = rpc;
    exc_req = exc; eret_req = eret; epc = ep;
  endtask

  // Decode consumes the F/D slot on an edge where it is valid and not stalled.
  task automatic step();
    exp_t e;
    @(negedge clk);
    if (!reset && if_valid && !stall) begin
      if (sbq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb_extra: got pc %h, expected no instruction", if_pc);
      end else begin
        e = sbq.pop_front();
        check("sb_pc", if_pc, e.pc);
        check("sb_instr", if_instr, e.instr);
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    drive(1'b1, 1'b0, 1'b0, 1'b0, '0, 1'b0, 1'b0, '0);

    //        rst stl rdy rv rpc           exc eret epc      chk req addr          v  ckpc ifpc
    tbl.push_back(mk(1, 0, 0, 0, 32'h0,        0, 0, 32'h0,    0, 0, 32'h0,        0, 0, 32'h0));
    tbl.push_back(mk(0, 0, 1, 0, 32'h0,        0, 0, 32'h0,    1, 0, 32'h3000,     0, 1, 32'h0));
    tbl.push_back(mk(0, 0, 1, 0, 32'h0,        0, 0, 32'h0,    1, 1, 32'h3000,     0, 0, 32'h0));
    tbl.push_back(mk(0, 0, 1, 0, 32'h0,        0, 0, 32'h0,    1, 1, 32'h3004,     1, 1, 32'h3000));
    tbl.push_back(mk(0, 0, 1, 0, 32'h0,        0, 0, 32'h0,    1, 1, 32'h3008,     1, 1, 32'h3004));
    tbl.push_back(mk(0, 0, 1, 0, 32'h0,        0, 0, 32'h0,    1, 1, 32'h300C,     1, 1, 32'h3008));
    tbl.push_back(mk(0, 0, 0, 0, 32'h0,        0, 0, 32'h0,    1, 1, 32'h3010,     1, 1, 32'h300C));
    tbl.push_back(mk(0, 0, 0, 1, 32'h3100,     0, 0, 32'h0,    1, 1, 32'h3010,     0, 0, 32'h0));
    tbl.push_back(mk(0, 0, 1, 0, 32'h0,        0, 0, 32'h0,    1, 1, 32'h3010,     0, 0, 32'h0));
    tbl.push_back(mk(0, 0, 1, 0, 32'h0,        0, 0, 32'h0,    1, 1, 32'h3100,     0, 0, 32'h0));
    tbl.push_back(mk(0, 1, 1, 0, 32'h0,        0, 0, 32'h0,    1, 1, 32'h3104,     1, 1, 32'h3100));
    tbl.push_back(mk(0, 1, 1, 0, 32'h0,        0, 0, 32'h0,    1, 0, 32'h3108,     1, 1, 32'h3100));
    tbl.push_back(mk(0, 0, 1, 0, 32'h0,        0, 0, 32'h0,    1, 0, 32'h3108,     1, 1, 32'h3100));
    tbl.push_back(mk(0, 0, 1, 0, 32'h0,        0, 0, 32'h0,    1, 1, 32'h3108,     1, 1, 32'h3104));
    tbl.push_back(mk(0, 0, 1, 1, 32'h3100,     1, 1, 32'h3040, 1, 1, 32'h310C,     1, 1, 32'h3108));
    tbl.push_back(mk(0, 0, 1, 0, 32'h0,        0, 0, 32'h0,    1, 1, 32'h4180,     0, 0, 32'h0));
    tbl.push_back(mk(0, 1, 1, 0, 32'h0,        0, 0, 32'h0,    1, 1, 32'h4184,     1, 1, 32'h4180));
    tbl.push_back(mk(0, 1, 1, 0, 32'h0,        0, 1, 32'h3040, 1, 0, 32'h4188,     1, 1, 32'h4180));
    tbl.push_back(mk(0, 0, 0, 0, 32'h0,        0, 0, 32'h0,    1, 1, 32'h3040,     0, 0, 32'h0));
    tbl.push_back(mk(0, 0, 1, 0, 32'h0,        0, 0, 32'h0,    1, 1, 32'h3040,     0, 0, 32'h0));
    tbl.push_back(mk(0, 0, 1, 0, 32'h0,        0, 0, 32'h0,    1, 1, 32'h3044,     1, 1, 32'h3040));
    tbl.push_back(mk(0, 0, 1, 1, 32'hFFFFFFFC, 0, 0, 32'h0,    1, 1, 32'h3048,     1, 1, 32'h3044));
    tbl.push_back(mk(0, 0, 1, 0, 32'h0,        0, 0, 32'h0,    1, 1, 32'hFFFFFFFC, 0, 0, 32'h0));
    tbl.push_back(mk(0, 0, 1, 0, 32'h0,        0, 0, 32'h0,    1, 1, 32'h0,        1, 1, 32'hFFFFFFFC));
    tbl.push_back(mk(1, 0, 1, 0, 32'h0,        0, 0, 32'h0,    1, 1, 32'h4,        1, 1, 32'h0));
    tbl.push_back(mk(0, 0, 0, 0, 32'h0,        0, 0, 32'h0,    1, 0, 32'h3000,     0, 1, 32'h0));
    tbl.push_back(mk(0, 0, 0, 0, 32'h0,        0, 0, 32'h0,    1, 1, 32'h3000,     0, 0, 32'h0));

    // Instructions decode should see, in order; squashed and skid-dropped words never appear.
    push_exp(32'h3000); push_exp(32'h3004); push_exp(32'h3008); push_exp(32'h300C);
    push_exp(32'h3100); push_exp(32'h3104); push_exp(32'h3108);
    push_exp(32'h3040); push_exp(32'h3044); push_exp(32'hFFFFFFFC);

    foreach (tbl[i]) begin
      if (tbl[i].chk) begin
        check($sformatf("row%0d_req", i), word_t'(bus.imem_req), word_t'(tbl[i].req));
        check($sformatf("row%0d_addr", i), bus.imem_addr, tbl[i].addr);
        check($sformatf("row%0d_if_valid", i), word_t'(if_valid), word_t'(tbl[i].v));
        if (tbl[i].v || tbl[i].ck_pc) begin
          check($sformatf("row%0d_if_pc", i), if_pc, tbl[i].ifpc);
        end
        if (tbl[i].ck_pc && !tbl[i].v) begin
          check($sformatf("row%0d_if_instr_rst", i), if_instr, 32'h0);
        end
      end
      drive(tbl[i].rst, tbl[i].stl, tbl[i].rdy, tbl[i].rv, tbl[i].rpc,
            tbl[i].exc, tbl[i].eret, tbl[i].epc);
      step();
    end

    // eret and branch together while waiting: eret target parked, address held.
    check("h_wait_addr", bus.imem_addr, 32'h3000);
    drive(1'b0, 1'b0, 1'b0, 1'b1, 32'h3300, 1'b0, 1'b1, 32'h3200);
    step();
    check("h_hold_addr", bus.imem_addr, 32'h3000);
    drive(1'b0, 1'b0, 1'b1, 1'b0, '0, 1'b0, 1'b0, '0);
    step();
    check("h_eret_over_branch", bus.imem_addr, 32'h3200);
    check("h_squash_valid", word_t'(if_valid), 32'h0);
    // Two redirects during one wait: the later target wins.
    drive(1'b0, 1'b0, 1'b0, 1'b1, 32'h3300, 1'b0, 1'b0, '0);
    step();
    check("h_pend1_addr", bus.imem_addr, 32'h3200);
    drive(1'b0, 1'b0, 1'b0, 1'b1, 32'h3400, 1'b0, 1'b0, '0);
    step();
    check("h_pend2_addr", bus.imem_addr, 32'h3200);
    drive(1'b0, 1'b0, 1'b1, 1'b0, '0, 1'b0, 1'b0, '0);
    step();
    check("h_overwrite_addr", bus.imem_addr, 32'h3400);
    check("h_overwrite_req", word_t'(bus.imem_req), 32'h1);
    push_exp(32'h3400);
    drive(1'b0, 1'b0, 1'b1, 1'b0, '0, 1'b0, 1'b0, '0);
    step();
    check("h_target_valid", word_t'(if_valid), 32'h1);
    drive(1'b0, 1'b0, 1'b0, 1'b0, '0, 1'b0, 1'b0, '0);
    step();
    step();

    check("sb_drained", word_t'(sbq.size()), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
